// File: rtl/bus_mux_pipe.sv
// Registered N-source bus multiplexer with one-hot select checking and fault latching.
// Optional feature: define BUS_MUX_PRIORITY_EN to accept multi-hot selects (lowest set bit wins).
module bus_mux_pipe #(
  parameter int WIDTH   = 16,
  parameter int NSRC    = 11,
  parameter int FAULT_N = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NSRC*WIDTH-1:0]     src_flat,
  input  logic [NSRC-1:0]           sel,
  input  logic                      sel_valid,
  input  logic                      clear_err,
  output logic [WIDTH-1:0]          bus,
  output logic                      bus_valid,
  output logic [$clog2(NSRC)-1:0]   bus_src,
  output logic                      sel_err,
  output logic [7:0]                err_count,
  output logic                      fault
);

  localparam int SRCW = $clog2(NSRC);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [3:0]      FAULT_LIM = 4'(FAULT_N);
  localparam logic [NSRC-1:0] SEL_ONE   = {{(NSRC-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [3:0]       r_consec;
  logic [WIDTH-1:0] r_bus;
  logic             r_bus_valid;
  logic [SRCW-1:0]  r_bus_src;
  logic             r_sel_err;
  logic [7:0]       r_err_count;
  logic             r_fault;

  logic [SRCW-1:0]  w_idx;
  logic [WIDTH-1:0] w_data;
  logic             w_onehot;
  logic             w_legal;
  logic [3:0]       w_consec_inc;

  // Lowest set select bit and its source word; descending scan lets the lowest index win.
  always_comb begin
    w_idx  = '0;
    w_data = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      w_idx  = sel[i] ? SRCW'(i) : w_idx;
      w_data = sel[i] ? src_flat[i*WIDTH +: WIDTH] : w_data;
    end
  end

  // Select legality and the candidate consecutive-error count.
  always_comb begin
    w_onehot     = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);
    w_consec_inc = r_consec + 4'd1;
`ifdef BUS_MUX_PRIORITY_EN
    w_legal      = (sel != '0);
`else
    w_legal      = w_onehot;
`endif
  end

  // Bus register, error bookkeeping and control state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_consec    <= 4'd0;
      r_bus       <= '0;
      r_bus_valid <= 1'b0;
      r_bus_src   <= '0;
      r_sel_err   <= 1'b0;
      r_err_count <= 8'd0;
      r_fault     <= 1'b0;
    end else if (clear_err) begin
      r_state     <= ST_IDLE;
      r_consec    <= 4'd0;
      r_bus_valid <= 1'b0;
      r_sel_err   <= 1'b0;
      r_err_count <= 8'd0;
      r_fault     <= 1'b0;
    end else if (r_state == ST_FAULT) begin
      r_bus_valid <= 1'b0;
      r_sel_err   <= 1'b0;
    end else if (sel_valid && w_legal) begin
      r_state     <= ST_DRIVE;
      r_consec    <= 4'd0;
      r_bus       <= w_data;
      r_bus_src   <= w_idx;
      r_bus_valid <= 1'b1;
      r_sel_err   <= 1'b0;
    end else if (sel_valid) begin
      r_consec    <= w_consec_inc;
      r_bus_valid <= 1'b0;
      r_sel_err   <= 1'b1;
      if (r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end else begin
        r_err_count <= r_err_count;
      end
      if (w_consec_inc == FAULT_LIM) begin
        r_state <= ST_FAULT;
        r_fault <= 1'b1;
      end else begin
        r_state <= r_state;
        r_fault <= 1'b0;
      end
    end else begin
      r_bus_valid <= 1'b0;
      r_sel_err   <= 1'b0;
      if (r_state == ST_DRIVE) begin
        r_state <= ST_IDLE;
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign bus       = r_bus;
  assign bus_valid = r_bus_valid;
  assign bus_src   = r_bus_src;
  assign sel_err   = r_sel_err;
  assign err_count = r_err_count;
  assign fault     = r_fault;

endmodule

// File: tb/tb_bus_mux_pipe.sv
// Self-checking bench for bus_mux_pipe: directed spec scenarios plus randomized traffic
// checked against a rule-level reference model.
module tb_bus_mux_pipe;

  localparam int W    = 16;
  localparam int NSRC = 11;
  localparam int FN   = 3;
  localparam int SW   = $clog2(NSRC);

  logic              clock;
  logic              reset;
  logic [W-1:0]      src [NSRC];
  logic [NSRC*W-1:0] src_flat;
  logic [NSRC-1:0]   sel;
  logic              sel_valid;
  logic              clear_err;
  logic [W-1:0]      bus;
  logic              bus_valid;
  logic [SW-1:0]     bus_src;
  logic              sel_err;
  logic [7:0]        err_count;
  logic              fault;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  int m_bus, m_src, m_valid, m_err, m_cnt, m_consec, m_fault;

  bus_mux_pipe #(.WIDTH(W), .NSRC(NSRC), .FAULT_N(FN)) dut (
    .clock(clock), .reset(reset), .src_flat(src_flat), .sel(sel),
    .sel_valid(sel_valid), .clear_err(clear_err), .bus(bus),
    .bus_valid(bus_valid), .bus_src(bus_src), .sel_err(sel_err),
    .err_count(err_count), .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < NSRC; i++) src_flat[i*W +: W] = src[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_bus = 0; m_src = 0; m_valid = 0; m_err = 0; m_cnt = 0; m_consec = 0; m_fault = 0;
  endtask

  // One clock of the specified behaviour, from the inputs present at the edge.
  task automatic model_step();
    bit legal;
    int idx;
`ifdef BUS_MUX_PRIORITY_EN
    legal = (sel != 0);
`else
    legal = ($countones(sel) == 1);
`endif
    idx = 0;
    for (int i = NSRC - 1; i >= 0; i--) if (sel[i]) idx = i;
    if (clear_err) begin
      m_cnt = 0; m_consec = 0; m_err = 0; m_valid = 0; m_fault = 0;
    end else if (m_fault != 0) begin
      m_valid = 0; m_err = 0;
    end else if (sel_valid && legal) begin
      m_bus = src[idx]; m_src = idx; m_valid = 1; m_err = 0; m_consec = 0;
    end else if (sel_valid) begin
      m_valid = 0; m_err = 1;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_consec = m_consec + 1;
      if (m_consec == FN) m_fault = 1;
    end else begin
      m_valid = 0; m_err = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bus"},       32'(bus),       32'(m_bus));
    chk({tag, ".bus_valid"}, 32'(bus_valid), 32'(m_valid));
    chk({tag, ".bus_src"},   32'(bus_src),   32'(m_src));
    chk({tag, ".sel_err"},   32'(sel_err),   32'(m_err));
    chk({tag, ".err_count"}, 32'(err_count), 32'(m_cnt));
    chk({tag, ".fault"},     32'(fault),     32'(m_fault));
  endtask

  task automatic cycle(input string tag);
    @(posedge clock);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [NSRC-1:0] s, input logic v, input logic c);
    sel = s; sel_valid = v; clear_err = c;
  endtask

  initial begin
    reset = 1'b1;
    sel = '0; sel_valid = 1'b0; clear_err = 1'b0;
    for (int i = 0; i < NSRC; i++) src[i] = W'(16'h1000 + i);
    model_reset();
    #2;
    check_all("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // Legal one-hot strobe on source 3
    src[3] = 16'hBEEF;
    drive(11'h008, 1'b1, 1'b0);
    cycle("legal_src3");
    chk("t2.bus", 32'(bus), 32'h0000_BEEF);
    chk("t2.bus_src", 32'(bus_src), 32'd3);
    chk("t2.bus_valid", 32'(bus_valid), 32'd1);

    // Zero select is illegal
    drive(11'h000, 1'b1, 1'b0);
    cycle("zero_sel");
    chk("t3.bus", 32'(bus), 32'h0000_BEEF);
    chk("t3.sel_err", 32'(sel_err), 32'd1);
    chk("t3.err_count", 32'(err_count), 32'd1);

    drive(11'h000, 1'b0, 1'b1);
    cycle("clear1");
    drive(11'h000, 1'b0, 1'b0);
    cycle("idle1");

`ifndef BUS_MUX_PRIORITY_EN
    // Three consecutive multi-hot strobes latch FAULT
    for (int k = 0; k < 3; k++) begin
      drive(11'h006, 1'b1, 1'b0);
      cycle("multihot");
    end
    chk("t4.fault", 32'(fault), 32'd1);
    chk("t4.err_count", 32'(err_count), 32'd3);
    src[5] = 16'h5555;
    drive(11'h020, 1'b1, 1'b0);
    cycle("fault_ignore");
    chk("t4.bus_held", 32'(bus), 32'h0000_BEEF);
    chk("t4.valid_in_fault", 32'(bus_valid), 32'd0);
    drive(11'h000, 1'b0, 1'b1);
    cycle("fault_clear");
    chk("t4.fault_cleared", 32'(fault), 32'd0);
    chk("t4.err_cleared", 32'(err_count), 32'd0);
`endif

    // clear_err beats a simultaneous legal strobe
    src[0] = 16'h0001;
    drive(11'h001, 1'b1, 1'b1);
    cycle("clear_vs_strobe");
    chk("t5.bus_valid", 32'(bus_valid), 32'd0);
    chk("t5.bus", 32'(bus), 32'(m_bus));

`ifdef BUS_MUX_PRIORITY_EN
    // Lowest set bit wins
    src[1] = 16'h00AA;
    drive(11'h006, 1'b1, 1'b0);
    cycle("priority");
    chk("t6.bus", 32'(bus), 32'h0000_00AA);
    chk("t6.bus_src", 32'(bus_src), 32'd1);
    chk("t6.sel_err", 32'(sel_err), 32'd0);
`endif

    // err_count saturation, with legal strobes breaking the consecutive run
    for (int k = 0; k < 260; k++) begin
      drive(11'h000, 1'b1, 1'b0);
      cycle("sat_bad");
      drive(11'h001, 1'b1, 1'b0);
      cycle("sat_good");
    end
    chk("sat.err_count", 32'(err_count), 32'd255);
    chk("sat.fault", 32'(fault), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NSRC; i++) src[i] = W'($urandom);
      case ($urandom_range(0, 3))
        0:       sel = '0;
        1:       sel = 11'(1) << $urandom_range(0, NSRC - 1);
        default: sel = 11'($urandom);
      endcase
      sel_valid = ($urandom_range(0, 3) != 0);
      clear_err = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end

    // Asynchronous reset mid-run with a known bus value
    drive(11'h000, 1'b0, 1'b1);
    cycle("pre_reset_clear");
    src[7] = 16'h1234;
    drive(11'h080, 1'b1, 1'b0);
    cycle("pre_reset_load");
    chk("t1.bus_loaded", 32'(bus), 32'h0000_1234);
    drive(11'h000, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clock); #1;
    reset = 1'b0;
    cycle("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
